// File: rtl/controle_pisca_leds.sv
// Blink timing and LED masking for the hit-LED sequence.
// Counts lit/dark phase lengths and completed dark phases for the control unit.
module controle_pisca_leds #(
   parameter  int ON_CYCLES  = 25_000_000,
   parameter  int OFF_CYCLES = 25_000_000,
   parameter  int N_PISCADAS = 3,
   localparam int PW         = $clog2(N_PISCADAS + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          contaLedsOn,
   input  logic          contaLedsOff,
   input  logic          contaPiscadas,
   input  logic          apagarAcertos,
   input  logic [3:0]    leds_acertos,
   output logic          fimLedsOn,
   output logic          fimLedsOff,
   output logic          fimPiscaLeds,
   output logic [3:0]    leds,
   output logic [PW-1:0] db_piscadas
);

   localparam int ONW  = $clog2(ON_CYCLES);
   localparam int OFFW = $clog2(OFF_CYCLES);

   localparam logic [ONW-1:0]  ON_LAST  = ONW'(ON_CYCLES - 1);
   localparam logic [OFFW-1:0] OFF_LAST = OFFW'(OFF_CYCLES - 1);
   localparam logic [PW-1:0]   P_MAX    = PW'(N_PISCADAS);
   localparam logic [PW-1:0]   P_LAST   = PW'(N_PISCADAS - 1);

   logic [ONW-1:0]  cnt_on_q, cnt_on_d;
   logic [OFFW-1:0] cnt_off_q, cnt_off_d;
   logic [PW-1:0]   cnt_p_q, cnt_p_d;
   logic [3:0]      leds_q, leds_d;

   logic on_sat, off_sat;

   assign on_sat  = (cnt_on_q == ON_LAST);
   assign off_sat = (cnt_off_q == OFF_LAST);

   assign fimLedsOn    = contaLedsOn && on_sat;
   assign fimLedsOff   = contaLedsOff && off_sat;
   assign fimPiscaLeds = contaLedsOn && (cnt_p_q == P_LAST);

   // Phase counters hold at their last value so fim stays high if the unit lingers
   always_comb begin
      cnt_on_d = '0;
      if (contaLedsOn)
         cnt_on_d = on_sat ? cnt_on_q : cnt_on_q + ONW'(1);
   end

   always_comb begin
      cnt_off_d = '0;
      if (contaLedsOff)
         cnt_off_d = off_sat ? cnt_off_q : cnt_off_q + OFFW'(1);
   end

   // Lit and dark phases abut, so only a true idle cycle restarts the count
   always_comb begin
      cnt_p_d = cnt_p_q;
      if (!contaLedsOn && !contaLedsOff)
         cnt_p_d = '0;
      else if (contaPiscadas && fimLedsOff && (cnt_p_q != P_MAX))
         cnt_p_d = cnt_p_q + PW'(1);
   end

   always_comb begin
      leds_d = apagarAcertos ? 4'b0000 : leds_acertos;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_on_q  <= '0;
         cnt_off_q <= '0;
         cnt_p_q   <= '0;
         leds_q    <= 4'b0000;
      end else begin
         cnt_on_q  <= cnt_on_d;
         cnt_off_q <= cnt_off_d;
         cnt_p_q   <= cnt_p_d;
         leds_q    <= leds_d;
      end
   end

   assign leds        = leds_q;
   assign db_piscadas = cnt_p_q;

endmodule

// File: doc/controle_pisca_leds.md
# controle_pisca_leds

Timing and masking stage for the hit-LED blink sequence. Sits directly downstream of the game control unit's blink states:
- Consumes the unit's `contaLedsOn`, `contaLedsOff`, `contaPiscadas` and `apagarAcertos` strobes.
- Returns `fimLedsOn`, `fimLedsOff` and `fimPiscaLeds` to that unit.
- Drives the board LEDs from the hit register, blanking them during off phases.

## Interface
- `ON_CYCLES`, default 25_000_000: clock cycles per lit phase; must be ≥ 2.
- `OFF_CYCLES`, default 25_000_000: clock cycles per dark phase; must be ≥ 2.
- `N_PISCADAS`, default 3: number of lit phases per sequence; must be ≥ 2.
- `clock`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `contaLedsOn`  input  1  high while the control unit is in its lit-phase state.
- `contaLedsOff`  input  1  high while the control unit is in its dark-phase state.
- `contaPiscadas`  input  1  blink-count enable; high together with `contaLedsOff`.
- `apagarAcertos`  input  1  blank request for the LED outputs.
- `leds_acertos`  input  4  current hit pattern from the hit register.
- `fimLedsOn`  output  1  last cycle of the current lit phase.
- `fimLedsOff`  output  1  last cycle of the current dark phase.
- `fimPiscaLeds`  output  1  current lit phase is the final one of the sequence.
- `leds`  output  4  registered LED drive.
- `db_piscadas`  output  `$clog2(N_PISCADAS+1)`  completed-dark-phase count, for debug.

## Operation
- **`cntOn`** (width `$clog2(ON_CYCLES)`)
  - Cleared to 0 on any cycle where `contaLedsOn`=0.
  - Otherwise increments, saturating at `ON_CYCLES-1`.
- **`fimLedsOn`** = `contaLedsOn` && `cntOn`==`ON_CYCLES-1`. Combinational from the register and the enable.
- **`cntOff`** and **`fimLedsOff`**: identical rules, using `contaLedsOff` and `OFF_CYCLES`.
- **`cntP`** (blink counter)
  - Increments when `contaPiscadas` && `fimLedsOff`, i.e. exactly once per completed dark phase.
  - Saturates at `N_PISCADAS`.
  - Cleared to 0 on any cycle where `contaLedsOn`=0 and `contaLedsOff`=0 (sequence idle).
  - The lit→dark and dark→lit transitions of the control unit leave no idle gap, so `cntP` survives a whole sequence.
- **`fimPiscaLeds`** = `contaLedsOn` && `cntP`==`N_PISCADAS-1`.
  - A sequence is therefore N lit phases separated by N-1 dark phases.
  - The control unit exits on `fimLedsOn` && `fimPiscaLeds`.
- **`leds`**: register loads 4'b0000 when `apagarAcertos`=1, else `leds_acertos`.
- **`db_piscadas`** = `cntP`.
- **Simultaneous enables** (`contaLedsOn` && `contaLedsOff`, illegal from the control unit):
  - Both counters run independently.
  - Each `fim` output is gated only by its own enable.
  - No lock-up.
- **`contaPiscadas` without `contaLedsOff`**: no effect, because `fimLedsOff` is 0.
- **Reset mid-sequence**
  - All counters are cleared and `leds`=0 at once.
  - If the enables are still high after reset release, counting restarts from 0 with a full-length phase.

## Timing
- **Reset values**: `cntOn`=`cntOff`=`cntP`=0, `leds`=4'b0000, `db_piscadas`=0. `fimLedsOn`, `fimLedsOff` and `fimPiscaLeds` are 0 while the enables are low.
- **Lit phase length**:
  - An enable rising at edge k gives `fimLedsOn` high during cycle k+`ON_CYCLES`-1.
  - The control unit samples it at the following edge, so each lit phase lasts exactly `ON_CYCLES` cycles.
  - Dark phases likewise last exactly `OFF_CYCLES` cycles.
- **Enable dropping early**: the counter is 0 in the next cycle, and no `fim` pulse is produced.
- **Enable held after `fim`** (control unit not leaving): `fim` stays high (saturated) until the enable drops.
- **`cntP` update**: it updates at the same edge at which the control unit leaves the dark phase, so the next lit phase already sees the new count.
- **`leds` latency**: one cycle. `apagarAcertos` rising at edge k blanks `leds` from edge k+1.

## Test plan
Parameters for all scenarios: `ON_CYCLES`=4, `OFF_CYCLES`=3, `N_PISCADAS`=3, driven by a control-unit model.
- **Full sequence**
  - Stimulus: on(4), off(3), on(4), off(3), on(4).
  - Required response:
    - `fimLedsOn` pulses in each on phase's 4th cycle.
    - `fimLedsOff` pulses in each off phase's 3rd cycle.
    - `fimPiscaLeds` is high only during the third on phase.
    - `db_piscadas` reads 1, then 2.
- **Early drop**: `contaLedsOn` high for 2 cycles, then low.
  - No `fimLedsOn`.
  - `cntOn` returns to 0.
  - A new 4-cycle phase completes normally.
- **Idle clear**: stop after 2 dark phases (`db_piscadas`=2), hold both enables low 1 cycle, restart.
  - `db_piscadas`=0.
  - `fimPiscaLeds` only in the third new on phase.
- **Masking**: `leds_acertos`=4'b0101, `apagarAcertos` pulsed 3 cycles.
  - `leds`=0101, then 0000 for exactly 3 cycles starting one cycle late, then 0101.
- **Reset mid-sequence**: assert `reset` asynchronously in the 2nd cycle of the second off phase.
  - `leds`=0 and `db_piscadas`=0 immediately.
  - With `contaLedsOff` held, `fimLedsOff` comes 3 cycles after release.
- **Saturation**: hold `contaLedsOn` for 10 cycles.
  - `fimLedsOn` is high from cycle 4 through cycle 10.
  - No counter wrap.
